// File: rtl/fault_filter_if.sv
// ============================================================================
// Module      : fault_filter_if
// Description : Wishbone register bus between a host and fault_filter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fault_filter_if #(
    parameter int ADDR_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] wb_addr;
    logic [31:0]           wb_dat_i;
    logic [31:0]           wb_dat_o;
    logic                  wb_we;
    logic [3:0]            wb_sel;
    logic                  wb_stb;
    logic                  wb_ack;

    modport master (
        output wb_addr, wb_dat_i, wb_we, wb_sel, wb_stb,
        input  wb_dat_o, wb_ack
    );

    modport slave (
        input  wb_addr, wb_dat_i, wb_we, wb_sel, wb_stb,
        output wb_dat_o, wb_ack
    );
endinterface

`default_nettype wire

// File: rtl/fault_filter.sv
// ============================================================================
// Module      : fault_filter
// Description : Synchronizes and debounces OCP/OVP/E-stop comparator pins
//               with per-channel run-length filters and glitch counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fault_filter #(
    parameter int ADDR_WIDTH     = 8,
    parameter int FILTER_DEFAULT = 50
) (
    input  wire logic         clk,
    input  wire logic         rst,
    fault_filter_if.slave     bus,
    input  wire logic         pin_ocp,
    input  wire logic         pin_ovp,
    input  wire logic         pin_estop_n,
    output logic              fault_ocp,
    output logic              fault_ovp,
    output logic              estop_n
);
    // Idle level per channel: OCP/OVP low, E-stop (active low) high
    localparam logic [2:0]  c_INACTIVE = 3'b100;
    localparam logic [15:0] c_LEN_RST  = 16'(FILTER_DEFAULT);

    logic [ADDR_WIDTH-1:0] w_addr;
    logic [5:0]            w_reg;
    logic                  w_acc;
    logic                  w_wr;
    logic                  w_rd;
    logic                  w_glitch_clr;
    logic [2:0]            w_pin;
    logic [2:0]            w_s;
    logic [2:0]            w_f;
    logic [15:0]           w_len    [3];
    logic [7:0]            w_glitch [3];
    logic [31:0]           w_rdata;
    logic                  w_unused;

    logic [2:0]            r_ctrl;
    logic                  r_ack;
    logic [31:0]           r_dat;

    assign w_addr       = bus.wb_addr;
    assign w_reg        = w_addr[7:2];
    assign w_acc        = bus.wb_stb && !r_ack;
    assign w_wr         = w_acc && bus.wb_we;
    assign w_rd         = w_acc && !bus.wb_we;
    assign w_glitch_clr = w_wr && (w_reg == 6'h05);
    assign w_pin        = {pin_estop_n, pin_ovp, pin_ocp};
    assign w_unused     = &{1'b0, bus.wb_sel, w_addr, bus.wb_dat_i};

    for (genvar i = 0; i < 3; i++) begin : g_ch
        logic [1:0]  r_sync;
        logic        r_f;
        logic [15:0] r_cnt;
        logic [15:0] r_len;
        logic [7:0]  r_glitch;
        logic [16:0] w_run;
        logic [16:0] w_eff_len;
        logic        w_fast;
        logic        w_len_wr;

        assign w_len_wr  = w_wr && (w_reg == 6'(i + 1));
        assign w_eff_len = (r_len == 16'd0) ? 17'd1 : {1'b0, r_len};
        assign w_run     = {1'b0, r_cnt} + 17'd1;
        // Fast path looks at the first sync flop so f asserts together with s
        assign w_fast    = r_ctrl[i] && (r_sync[0] != c_INACTIVE[i]);

        always_ff @(posedge clk) begin
            if (rst) begin
                r_sync   <= {2{c_INACTIVE[i]}};
                r_f      <= c_INACTIVE[i];
                r_cnt    <= 16'd0;
                r_len    <= c_LEN_RST;
                r_glitch <= 8'd0;
            end else begin
                r_sync <= {r_sync[0], w_pin[i]};
                if (w_len_wr) begin
                    r_len <= bus.wb_dat_i[15:0];
                end
                if (r_sync[1] != r_f) begin
                    if (w_run >= w_eff_len) begin
                        r_f   <= r_sync[1];
                        r_cnt <= 16'd0;
                    end else begin
                        r_cnt <= w_run[15:0];
                    end
                end else begin
                    r_cnt <= 16'd0;
                end
                if (w_fast) begin
                    r_f   <= ~c_INACTIVE[i];
                    r_cnt <= 16'd0;
                end
                if (w_glitch_clr) begin
                    r_glitch <= 8'd0;
                end else if ((r_sync[1] == r_f) && (r_cnt != 16'd0) && (r_glitch != 8'hFF)) begin
                    r_glitch <= r_glitch + 8'd1;
                end
            end
        end

        assign w_s[i]      = r_sync[1];
        assign w_f[i]      = r_f;
        assign w_len[i]    = r_len;
        assign w_glitch[i] = r_glitch;
    end

    always_comb begin
        w_rdata = 32'd0;
        case (w_reg)
            6'h00: w_rdata[2:0]  = r_ctrl;
            6'h01: w_rdata[15:0] = w_len[0];
            6'h02: w_rdata[15:0] = w_len[1];
            6'h03: w_rdata[15:0] = w_len[2];
            6'h04: begin
                w_rdata[2:0] = w_s;
                w_rdata[6:4] = w_f;
            end
            6'h05: w_rdata[23:0] = {w_glitch[2], w_glitch[1], w_glitch[0]};
            default: w_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctrl <= 3'd0;
            r_ack  <= 1'b0;
            r_dat  <= 32'd0;
        end else begin
            r_ack <= bus.wb_stb && !r_ack;
            if (w_wr && (w_reg == 6'h00)) begin
                r_ctrl <= bus.wb_dat_i[2:0];
            end
            if (w_rd) begin
                r_dat <= w_rdata;
            end
        end
    end

    assign bus.wb_ack   = r_ack;
    assign bus.wb_dat_o = r_dat;
    assign fault_ocp    = w_f[0];
    assign fault_ovp    = w_f[1];
    assign estop_n      = w_f[2];

endmodule

`default_nettype wire

// File: tb/tb_fault_filter.sv
// ============================================================================
// Module      : tb_fault_filter
// Description : Directed and randomized checks of fault_filter against a
//               behavioural per-cycle reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fault_filter;
    localparam int ADDR_WIDTH     = 8;
    localparam int FILTER_DEFAULT = 50;

    logic clk = 1'b0;
    logic rst;
    logic pin_ocp, pin_ovp, pin_estop_n;
    wire  fault_ocp, fault_ovp, estop_n;

    int n_checks = 0;
    int n_errors = 0;

    fault_filter_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();

    fault_filter #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .FILTER_DEFAULT (FILTER_DEFAULT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .pin_ocp     (pin_ocp),
        .pin_ovp     (pin_ovp),
        .pin_estop_n (pin_estop_n),
        .fault_ocp   (fault_ocp),
        .fault_ovp   (fault_ovp),
        .estop_n     (estop_n)
    );

    always #5 clk = ~clk;

    // Reference model state
    bit        m_s1 [3];
    bit        m_s  [3];
    bit        m_f  [3];
    int        m_cnt[3];
    int        m_len[3];
    int        m_g  [3];
    bit [2:0]  m_ctrl;
    bit        m_ack;
    bit [31:0] m_dat;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit [31:0] model_read(input int idx);
        case (idx)
            0:       return {29'd0, m_ctrl};
            1, 2, 3: return 32'(m_len[idx-1]);
            4:       return {25'd0, m_f[2], m_f[1], m_f[0], 1'b0, m_s[2], m_s[1], m_s[0]};
            5:       return {8'd0, 8'(m_g[2]), 8'(m_g[1]), 8'(m_g[0])};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step();
        bit [2:0]  pins;
        bit        acc, clr, act;
        int        idx, len_eff;
        bit [31:0] rdata;
        pins = {pin_estop_n, pin_ovp, pin_ocp};
        if (rst) begin
            for (int ch = 0; ch < 3; ch++) begin
                act       = (ch != 2);
                m_s1[ch]  = !act;
                m_s[ch]   = !act;
                m_f[ch]   = !act;
                m_cnt[ch] = 0;
                m_g[ch]   = 0;
                m_len[ch] = FILTER_DEFAULT;
            end
            m_ctrl = 3'd0;
            m_ack  = 1'b0;
            m_dat  = 32'd0;
            return;
        end
        acc   = bus.wb_stb && !m_ack;
        idx   = int'(bus.wb_addr[7:2]);
        rdata = model_read(idx);
        clr   = acc && bus.wb_we && (idx == 5);
        for (int ch = 0; ch < 3; ch++) begin
            act     = (ch != 2);
            len_eff = (m_len[ch] == 0) ? 1 : m_len[ch];
            if (m_s[ch] != m_f[ch]) begin
                if (m_cnt[ch] + 1 >= len_eff) begin
                    m_f[ch]   = m_s[ch];
                    m_cnt[ch] = 0;
                end else begin
                    m_cnt[ch] = m_cnt[ch] + 1;
                end
            end else begin
                if (m_cnt[ch] != 0 && m_g[ch] < 255) m_g[ch] = m_g[ch] + 1;
                m_cnt[ch] = 0;
            end
            if (m_ctrl[ch] && (m_s1[ch] == act)) begin
                m_f[ch]   = act;
                m_cnt[ch] = 0;
            end
            if (clr) m_g[ch] = 0;
            m_s[ch]  = m_s1[ch];
            m_s1[ch] = pins[ch];
        end
        if (acc && bus.wb_we) begin
            if (idx == 0) m_ctrl = bus.wb_dat_i[2:0];
            if (idx >= 1 && idx <= 3) m_len[idx-1] = int'(bus.wb_dat_i[15:0]);
        end
        if (acc && !bus.wb_we) m_dat = rdata;
        m_ack = bus.wb_stb && !m_ack;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("fault_ocp", 32'(fault_ocp), 32'(m_f[0]));
        check("fault_ovp", 32'(fault_ovp), 32'(m_f[1]));
        check("estop_n",   32'(estop_n),   32'(m_f[2]));
        check("wb_ack",    32'(bus.wb_ack), 32'(m_ack));
        check("wb_dat_o",  bus.wb_dat_o,    m_dat);
    endtask

    task automatic wb_write(input logic [7:0] a, input logic [31:0] d);
        if (bus.wb_ack) tick();
        bus.wb_addr  = a;
        bus.wb_dat_i = d;
        bus.wb_we    = 1'b1;
        bus.wb_stb   = 1'b1;
        tick();
        bus.wb_stb   = 1'b0;
        bus.wb_we    = 1'b0;
    endtask

    task automatic wb_read(input logic [7:0] a, output logic [31:0] d);
        if (bus.wb_ack) tick();
        bus.wb_addr = a;
        bus.wb_we   = 1'b0;
        bus.wb_stb  = 1'b1;
        tick();
        d = bus.wb_dat_o;
        bus.wb_stb  = 1'b0;
    endtask

    function automatic logic out_of(input int ch);
        case (ch)
            0:       return fault_ocp;
            1:       return fault_ovp;
            default: return estop_n;
        endcase
    endfunction

    task automatic measure(input int ch, input logic val, output int n);
        n = -1;
        for (int k = 1; k <= 500; k++) begin
            tick();
            if (out_of(ch) == val) begin
                n = k;
                break;
            end
        end
    endtask

    initial begin
        logic [31:0] rd;
        int          n;
        bit          seen;

        rst = 1'b1;
        pin_ocp = 1'b0; pin_ovp = 1'b0; pin_estop_n = 1'b1;
        bus.wb_addr = '0; bus.wb_dat_i = '0; bus.wb_we = 1'b0;
        bus.wb_sel = 4'hF; bus.wb_stb = 1'b0;
        repeat (3) tick();
        check("rst_fault_ocp", 32'(fault_ocp), 32'd0);
        check("rst_fault_ovp", 32'(fault_ovp), 32'd0);
        check("rst_estop_n",   32'(estop_n),   32'd1);
        check("rst_ack",       32'(bus.wb_ack), 32'd0);
        check("rst_dat",       bus.wb_dat_o,    32'd0);
        rst = 1'b0;
        tick();
        wb_read(8'h04, rd); check("rst_ocp_len", rd, 32'(FILTER_DEFAULT));
        wb_read(8'h00, rd); check("rst_ctrl", rd, 32'd0);

        // Filtered latency, both directions
        wb_write(8'h04, 32'd4);
        pin_ocp = 1'b1; measure(0, 1'b1, n); check("ocp_rise_lat", 32'(n), 32'd6);
        pin_ocp = 1'b0; measure(0, 1'b0, n); check("ocp_fall_lat", 32'(n), 32'd6);

        // Short OVP pulse is rejected and counted as a glitch
        wb_write(8'h14, 32'd0);
        wb_write(8'h08, 32'd4);
        seen = 1'b0;
        pin_ovp = 1'b1;
        repeat (3) begin tick(); seen |= fault_ovp; end
        pin_ovp = 1'b0;
        repeat (10) begin tick(); seen |= fault_ovp; end
        check("ovp_glitch_out", 32'(seen), 32'd0);
        wb_read(8'h14, rd); check("ovp_glitch_cnt", (rd >> 8) & 32'hFF, 32'd1);

        // Fast E-stop assertion, filtered release
        wb_write(8'h00, 32'h4);
        wb_write(8'h0C, 32'd100);
        pin_estop_n = 1'b0; measure(2, 1'b0, n); check("estop_fast_lat", 32'(n), 32'd2);
        pin_estop_n = 1'b1; measure(2, 1'b1, n); check("estop_rel_lat", 32'(n), 32'd102);
        wb_write(8'h00, 32'h0);

        // LEN=0 acts as 1; shortening LEN mid-run
        wb_write(8'h04, 32'd0);
        pin_ocp = 1'b1; measure(0, 1'b1, n); check("ocp_len0_lat", 32'(n), 32'd3);
        wb_write(8'h04, 32'd1000);
        pin_ocp = 1'b0;
        repeat (22) tick();
        wb_write(8'h04, 32'd10);
        check("ocp_len_wr_edge", 32'(fault_ocp), 32'd1);
        tick();
        check("ocp_len_wr_next", 32'(fault_ocp), 32'd0);

        // Glitch saturation and clearing
        wb_write(8'h14, 32'd0);
        repeat (300) begin
            pin_ocp = 1'b1; tick();
            pin_ocp = 1'b0; repeat (3) tick();
        end
        wb_read(8'h14, rd);  check("glitch_sat", rd & 32'hFF, 32'd255);
        wb_write(8'h14, 32'hDEAD);
        wb_read(8'h14, rd);  check("glitch_clr", rd & 32'hFF, 32'd0);
        pin_ocp = 1'b1; tick();
        pin_ocp = 1'b0; tick(); tick();
        wb_write(8'h14, 32'd0);
        wb_read(8'h14, rd);  check("glitch_clr_wins", rd & 32'hFF, 32'd0);
        wb_read(8'h18, rd);  check("unmapped_read", rd, 32'd0);

        // Reset in the middle of an active fault
        wb_write(8'h08, 32'd2);
        pin_ovp = 1'b1; measure(1, 1'b1, n); check("ovp_assert", 32'(n), 32'd4);
        rst = 1'b1;
        tick();
        check("rst_mid_ovp",   32'(fault_ovp), 32'd0);
        check("rst_mid_estop", 32'(estop_n),   32'd1);
        check("rst_mid_ack",   32'(bus.wb_ack), 32'd0);
        rst = 1'b0;
        pin_ovp = 1'b0;
        tick();
        wb_read(8'h08, rd); check("rst_mid_len", rd, 32'(FILTER_DEFAULT));

        // Randomized traffic against the reference model
        for (int it = 0; it < 4000; it++) begin
            if ($urandom_range(0, 7) == 0) pin_ocp     = ~pin_ocp;
            if ($urandom_range(0, 7) == 0) pin_ovp     = ~pin_ovp;
            if ($urandom_range(0, 7) == 0) pin_estop_n = ~pin_estop_n;
            rst          = ($urandom_range(0, 599) == 0);
            bus.wb_stb   = ($urandom_range(0, 3) == 0);
            bus.wb_we    = 1'($urandom_range(0, 1));
            bus.wb_addr  = {3'(($urandom_range(0, 9) == 0) ? $urandom_range(0, 7) : 0),
                            3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            bus.wb_dat_i = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 6));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
